tdc_multistop: RTL and testbench
================================

Name: tdc_multistop

Overview:
- Parametrised successor to the two-input TDC. One START channel and NUM_STOP STOP channels.
- Measures START-to-STOP intervals in clk cycles, inside a bounded window.
- Supports single-hit or multi-hit capture per channel and retriggerable windows.
- Results are queued in an event FIFO with a valid/ready output, feeding the coincidence/counting logic of the single-pixel imaging datapath.

Parameters:
- NUM_STOP, 4: number of STOP channels (1..16).
- CNT_W, 12: interval counter width.
- WINDOW, 1000: window length in cycles. Elaboration check: 2 ≤ WINDOW ≤ 2^CNT_W.
- FIFO_DEPTH, 16: event FIFO depth (power of 2).
- SYNC_STAGES, 2: input synchroniser depth (≥2).
- RETRIGGER, 1: 1 = START edge during window restarts it; 0 = ignored.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- start_in  in  1  async START pulse; high ≥1 clk period.
- stop_in  in  NUM_STOP  async STOP pulses; each high ≥1 clk period.
- multi_hit  in  1  0 = first hit per channel per window; 1 = every hit.
- evt_valid  out  1  event available.
- evt_ready  in  1  consumer accepts event.
- evt_chan  out  $clog2(NUM_STOP) (min 1)  STOP channel index.
- evt_interval  out  CNT_W  cycles from START edge to STOP edge.
- busy  out  1  window open (state ARMED).
- fifo_full  out  1  event FIFO full.
- drop_cnt  out  16  lost events, saturating at 16'hFFFF.

Behaviour:
- **Reset:** synchronous and active-high. All outputs are 0, the FIFO is empty, state is IDLE, and counter, hit mask and pending regs are cleared.
- **Reset mid-operation:** same result the cycle after rst is sampled. Anything in flight is discarded.
- **Input path:** each input passes through SYNC_STAGES flops, then a rising-edge detect (sync & ~sync_d). START and STOP share the same latency, so it cancels out of the interval.
- **FSM states:** IDLE, ARMED.
- **IDLE → ARMED:** on a START edge. Counter := 0 and hit_mask := 0 in that cycle.
- **ARMED:** counter increments by 1 each cycle. A STOP edge detected k cycles after the START edge yields interval k (k ≥ 1).
- **ARMED → IDLE:** when counter == WINDOW-1 with no START edge. STOP edges in that same cycle are still captured.
- **START edge in ARMED, RETRIGGER=1:** counter := 0 and hit_mask := 0. STOP edges in the same cycle are captured with the old counter value.
- **START edge in ARMED, RETRIGGER=0:** ignored.
- **STOP edge in IDLE,** including the cycle of the IDLE START edge: ignored, no event.
- **Capture:** a STOP edge on channel c in ARMED, with multi_hit=1 or hit_mask[c]=0, sets pend[c], stores {c, counter} in channel c's pending reg, and sets hit_mask[c].
- **Pending already occupied:** if pend[c] is set when a new capture arrives, the new hit is dropped and drop_cnt increments.
- **Arbiter:** each cycle, if the FIFO is not full, the lowest-index pending channel is written to the FIFO and its pend bit cleared. A channel may be cleared and re-captured in the same cycle (write wins the slot).
- **Drops counted:** multiple drops in one cycle add their count to drop_cnt, which saturates.
- **Latency:** edge detected at cycle E → pend set at E+1 → FIFO write at E+1 (if uncontended) → evt_valid at E+2. Simultaneous hits emerge on consecutive cycles in ascending channel order.
- **FIFO and output handshake:**
  - Standard FIFO with registered outputs.
  - A transfer occurs when evt_valid && evt_ready.
  - evt_chan and evt_interval are stable while evt_valid && !evt_ready.
  - fifo_full is asserted at FIFO_DEPTH entries.
  - Simultaneous push and pop when full is allowed.
- **Pending draining:** pending entries keep draining after the window closes.

Decomposition:
- **Package tdc_pkg:** state enum (IDLE, ARMED), event struct {chan, interval}, and a CHAN_W localparam function.
- **Sub-module tdc_evt_fifo:** a parametrised synchronous FIFO (width, depth) with valid/ready output, full flag, and synchronous active-high rst.
- **Kept in the top:** synchronisers, edge detect, FSM, counter, pending regs, arbiter and drop counter.

Test Plan (NUM_STOP=4, CNT_W=12, WINDOW=64, FIFO_DEPTH=16, evt_ready=1 unless stated):
- START pulse, stop_in[0] pulse 10 cycles later → one event chan=0, interval=10; busy falls 64 cycles after the START edge.
- stop_in[1] and stop_in[2] rise together 5 cycles after START → events (1,5) then (2,5) on consecutive cycles.
- multi_hit=0, stop_in[3] at +3 and +8 → only (3,3). Repeat with multi_hit=1 → (3,3) then (3,8). drop_cnt=0 in both cases.
- Window boundary, no STOP:
  - STOP at +70 → no event; busy=0 from cycle +64.
  - With RETRIGGER=1, a second START at +30 then STOP at +40 → interval 10.
  - Same sequence with RETRIGGER=0 → interval 40.
- evt_ready=0, multi_hit=1, stop_in[0] pulsed 22 times → 16 FIFO entries + 1 pending. Following hits arrive while pending is occupied → drop_cnt=5. Then raise evt_ready → 17 events in order, intervals increasing.
- rst asserted 1 cycle mid-window with 3 pend bits set → next cycle busy=0, evt_valid=0, drop_cnt=0, and no events afterwards.

Source files
------------

// File: rtl/tdc_pkg.sv
// tdc_multistop shared types.
// FSM state and channel index width helper.
package tdc_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    ARMED = 1'b1
  } state_t;

  function automatic int chan_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/tdc_evt_fifo.sv
// Event FIFO for tdc_multistop.
// Sync reset, valid/ready pop side, full flag.
module tdc_evt_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         push,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         valid,
  input  logic         ready,
  output logic [W-1:0] dout
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wp;
  logic [AW-1:0] rp;
  logic [CW-1:0] count;
  logic          pop;
  logic          wr;

  assign valid = (count != '0);
  assign full  = (count == CW'(DEPTH));
  assign pop   = valid && ready;
  assign wr    = push && (!full || pop);
  assign dout  = valid ? mem[rp] : '0;

  // Storage array, written at the tail.
  always_ff @(posedge clk) begin
    if (wr) mem[wp] <= din;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (wr)  wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      case ({wr, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/tdc_multistop.sv
// Multi-stop TDC: one START, NUM_STOP STOPs,
// windowed intervals queued as events.
module tdc_multistop
  import tdc_pkg::*;
#(
  parameter int NUM_STOP    = 4,
  parameter int CNT_W       = 12,
  parameter int WINDOW      = 1000,
  parameter int FIFO_DEPTH  = 16,
  parameter int SYNC_STAGES = 2,
  parameter int RETRIGGER   = 1
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start_in,
  input  logic [NUM_STOP-1:0]         stop_in,
  input  logic                        multi_hit,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [chan_w(NUM_STOP)-1:0] evt_chan,
  output logic [CNT_W-1:0]            evt_interval,
  output logic                        busy,
  output logic                        fifo_full,
  output logic [15:0]                 drop_cnt
);

  localparam int CHAN_W = chan_w(NUM_STOP);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(WINDOW - 1);

  if (WINDOW < 2 || WINDOW > (1 << CNT_W)) begin : g_bad_win
    $error("tdc_multistop: WINDOW out of range");
  end
  if (NUM_STOP < 1 || NUM_STOP > 16) begin : g_bad_ns
    $error("tdc_multistop: NUM_STOP out of range");
  end
  if (SYNC_STAGES < 2) begin : g_bad_sync
    $error("tdc_multistop: SYNC_STAGES < 2");
  end
  if (FIFO_DEPTH < 2 ||
      (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_fd
    $error("tdc_multistop: FIFO_DEPTH not pow2");
  end

  typedef struct packed {
    logic [CHAN_W-1:0] chan;
    logic [CNT_W-1:0]  interval;
  } evt_t;

  localparam int EVT_W = $bits(evt_t);

  logic [NUM_STOP:0]   sync_q [SYNC_STAGES];
  logic [NUM_STOP:0]   sync_d;
  logic [NUM_STOP:0]   edges;
  logic                start_e;
  logic [NUM_STOP-1:0] stop_e;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [NUM_STOP-1:0] mask;

  logic [NUM_STOP-1:0] pend;
  logic [CNT_W-1:0]    pend_iv [NUM_STOP];
  logic [NUM_STOP-1:0] cap;
  logic [NUM_STOP-1:0] accept;
  logic [NUM_STOP-1:0] drop;
  logic [NUM_STOP-1:0] grant;
  logic                push;
  evt_t                din;
  logic [EVT_W-1:0]    fifo_q;
  evt_t                evt_q;
  logic [4:0]          ndrop;
  logic [16:0]         drop_sum;

  // Synchronise START and STOPs through equal-depth chains.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++)
        sync_q[i] <= '0;
      sync_d <= '0;
    end else begin
      sync_q[0] <= {stop_in, start_in};
      for (int i = 1; i < SYNC_STAGES; i++)
        sync_q[i] <= sync_q[i-1];
      sync_d <= sync_q[SYNC_STAGES-1];
    end
  end

  assign edges   = sync_q[SYNC_STAGES-1] & ~sync_d;
  assign start_e = edges[0];
  assign stop_e  = edges[NUM_STOP:1];

  assign busy = (state == ARMED);

  // The START edge cycle is count 0, so the counter
  // reads k exactly k cycles after that edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      mask  <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start_e) begin
            state <= ARMED;
            cnt   <= CNT_W'(1);
            mask  <= '0;
          end
        end
        ARMED: begin
          if (start_e && RETRIGGER != 0) begin
            cnt  <= CNT_W'(1);
            mask <= '0;
          end else if (cnt == LAST) begin
            state <= IDLE;
            cnt   <= '0;
          end else begin
            cnt  <= cnt + CNT_W'(1);
            mask <= mask | cap;
          end
        end
      endcase
    end
  end

  assign cap = busy ?
    (stop_e & ({NUM_STOP{multi_hit}} | ~mask)) : '0;

  assign grant = fifo_full ? '0 :
    (pend & (~pend + NUM_STOP'(1)));

  assign push   = |grant;
  assign accept = cap & (~pend | grant);
  assign drop   = cap & ~accept;

  // Lowest-index pending channel feeds the FIFO.
  always_comb begin
    din = '0;
    for (int i = NUM_STOP - 1; i >= 0; i--) begin
      if (pend[i]) begin
        din.chan     = CHAN_W'(i);
        din.interval = pend_iv[i];
      end
    end
  end

  // One-deep pending slot per channel.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend <= '0;
      for (int i = 0; i < NUM_STOP; i++)
        pend_iv[i] <= '0;
    end else begin
      pend <= (pend & ~grant) | accept;
      for (int i = 0; i < NUM_STOP; i++)
        if (accept[i]) pend_iv[i] <= cnt;
    end
  end

  // Number of hits lost this cycle.
  always_comb begin
    ndrop = '0;
    for (int i = 0; i < NUM_STOP; i++)
      ndrop = ndrop + 5'(drop[i]);
  end

  assign drop_sum = {1'b0, drop_cnt} + 17'(ndrop);

  // Saturating drop counter.
  always_ff @(posedge clk) begin
    if (rst)
      drop_cnt <= '0;
    else if (drop_sum[16])
      drop_cnt <= 16'hFFFF;
    else
      drop_cnt <= drop_sum[15:0];
  end

  tdc_evt_fifo #(
    .W     (EVT_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .din   (din),
    .full  (fifo_full),
    .valid (evt_valid),
    .ready (evt_ready),
    .dout  (fifo_q)
  );

  assign evt_q        = fifo_q;
  assign evt_chan     = evt_q.chan;
  assign evt_interval = evt_q.interval;

endmodule

// File: tb/tb_tdc_multistop.sv
// Bench for tdc_multistop: table vectors, corner
// sequences and random stimulus against a time model.
module tb_tdc_multistop;

  localparam int WIN = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        start_in;
  logic [3:0]  stop_in;
  logic        multi_hit;
  logic        evt_ready;

  wire  [1:0]  vld;
  wire  [1:0]  busy_o;
  wire  [1:0]  full_o;
  wire  [1:0]  chan_o [2];
  wire  [11:0] iv_o [2];
  wire  [15:0] drop_o [2];

  int n_chk  = 0;
  int n_pass = 0;
  int t      = 0;

  typedef struct {
    int chan;
    int iv;
    int cyc;
  } ev_t;

  ev_t obs [2][$];

  typedef struct {
    int         st2;
    logic [3:0] m1;
    int         o1;
    logic [3:0] m2;
    int         o2;
    logic       multi;
    int         n1;
    int         c1a;
    int         i1a;
    int         c1b;
    int         i1b;
    int         n0;
    int         c0a;
    int         i0a;
    int         c0b;
    int         i0b;
    logic       consec;
  } vec_t;

  vec_t vt [6];

  // Reference model state: index 0 retriggers, 1 does not.
  int         ws [2];
  logic [3:0] hit [2];
  int         expq [8][$];

  tdc_multistop #(
    .NUM_STOP(4), .CNT_W(12), .WINDOW(WIN),
    .FIFO_DEPTH(16), .SYNC_STAGES(2), .RETRIGGER(1)
  ) dut_rt1 (
    .clk(clk), .rst(rst), .start_in(start_in),
    .stop_in(stop_in), .multi_hit(multi_hit),
    .evt_valid(vld[0]), .evt_ready(evt_ready),
    .evt_chan(chan_o[0]), .evt_interval(iv_o[0]),
    .busy(busy_o[0]), .fifo_full(full_o[0]),
    .drop_cnt(drop_o[0])
  );

  tdc_multistop #(
    .NUM_STOP(4), .CNT_W(12), .WINDOW(WIN),
    .FIFO_DEPTH(16), .SYNC_STAGES(2), .RETRIGGER(0)
  ) dut_rt0 (
    .clk(clk), .rst(rst), .start_in(start_in),
    .stop_in(stop_in), .multi_hit(multi_hit),
    .evt_valid(vld[1]), .evt_ready(evt_ready),
    .evt_chan(chan_o[1]), .evt_interval(iv_o[1]),
    .busy(busy_o[1]), .fifo_full(full_o[1]),
    .drop_cnt(drop_o[1])
  );

  always #5 clk = ~clk;

  // Record every accepted transfer of both instances.
  always @(negedge clk) begin
    if (!rst) begin
      for (int r = 0; r < 2; r++)
        if (vld[r] && evt_ready)
          obs[r].push_back('{chan: int'(chan_o[r]),
                             iv: int'(iv_o[r]),
                             cyc: t});
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
    t++;
  endtask

  task automatic check(input string nm,
                       input longint act,
                       input longint exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d",
                  nm, act, exp);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    start_in = 1'b0;
    stop_in = '0;
    repeat (3) tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic chk_vec(input int v, input int r,
                         input int n,
                         input int ca, input int ia,
                         input int cb, input int ib);
    string p;
    p = $sformatf("v%0d_r%0d", v, r);
    check({p, "_count"}, obs[r].size(), n);
    if (n >= 1 && obs[r].size() >= 1) begin
      check({p, "_chan0"}, obs[r][0].chan, ca);
      check({p, "_iv0"}, obs[r][0].iv, ia);
    end
    if (n >= 2 && obs[r].size() >= 2) begin
      check({p, "_chan1"}, obs[r][1].chan, cb);
      check({p, "_iv1"}, obs[r][1].iv, ib);
    end
  endtask

  function automatic bit is_open(input int r,
                                 input int tt);
    return (tt - ws[r] >= 1) &&
           (tt - ws[r] <= WIN - 1);
  endfunction

  // Window rules on the input timeline.
  task automatic model_step(input logic srise,
                            input logic [3:0] prise);
    for (int r = 0; r < 2; r++) begin
      bit op;
      op = is_open(r, t);
      for (int c = 0; c < 4; c++) begin
        if (prise[c] && op &&
            (multi_hit || !hit[r][c])) begin
          expq[r*4+c].push_back(t - ws[r]);
          hit[r][c] = 1'b1;
        end
      end
      if (srise && (!op || r == 0)) begin
        ws[r]  = t;
        hit[r] = '0;
      end
    end
  endtask

  initial begin
    vec_t x;
    int   bc [2];
    int   gap [4];
    int   tot;
    int   act [$];
    logic ns;
    logic [3:0] nstop;

    vt[0] = '{0, 4'b0001, 10, 4'b0000, 0, 1'b1,
              1, 0, 10, 0, 0, 1, 0, 10, 0, 0, 1'b0};
    vt[1] = '{0, 4'b0110, 5, 4'b0000, 0, 1'b1,
              2, 1, 5, 2, 5, 2, 1, 5, 2, 5, 1'b1};
    vt[2] = '{0, 4'b1000, 3, 4'b1000, 8, 1'b0,
              1, 3, 3, 0, 0, 1, 3, 3, 0, 0, 1'b0};
    vt[3] = '{0, 4'b1000, 3, 4'b1000, 8, 1'b1,
              2, 3, 3, 3, 8, 2, 3, 3, 3, 8, 1'b0};
    vt[4] = '{0, 4'b0001, 70, 4'b0000, 0, 1'b1,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0};
    vt[5] = '{30, 4'b0001, 40, 4'b0000, 0, 1'b1,
              1, 0, 10, 0, 0, 1, 0, 40, 0, 0, 1'b0};

    rst = 1'b1;
    start_in = 1'b0;
    stop_in = '0;
    multi_hit = 1'b0;
    evt_ready = 1'b1;
    repeat (3) tick();
    check("rst_busy", busy_o[0], 0);
    check("rst_valid", vld[0], 0);
    check("rst_full", full_o[0], 0);
    check("rst_drop", drop_o[0], 0);
    check("rst_chan", chan_o[0], 0);
    check("rst_iv", iv_o[0], 0);
    rst = 1'b0;
    repeat (4) tick();

    // Table-driven single-window scenarios.
    for (int v = 0; v < 6; v++) begin
      x = vt[v];
      multi_hit = x.multi;
      obs[0].delete();
      obs[1].delete();
      bc[0] = 0;
      bc[1] = 0;
      for (int o = 0; o < 110; o++) begin
        start_in = (o == 0) ||
                   (x.st2 != 0 && o == x.st2);
        stop_in = ((o == x.o1) ? x.m1 : 4'b0000) |
                  ((o == x.o2) ? x.m2 : 4'b0000);
        tick();
        bc[0] += int'(busy_o[0]);
        bc[1] += int'(busy_o[1]);
      end
      chk_vec(v, 0, x.n1, x.c1a, x.i1a, x.c1b, x.i1b);
      chk_vec(v, 1, x.n0, x.c0a, x.i0a, x.c0b, x.i0b);
      check($sformatf("v%0d_busy_r1", v), bc[0],
            (x.st2 != 0) ? x.st2 + WIN - 1 : WIN - 1);
      check($sformatf("v%0d_busy_r0", v), bc[1],
            WIN - 1);
      check($sformatf("v%0d_drop", v), drop_o[0], 0);
      if (x.consec && obs[0].size() >= 2)
        check($sformatf("v%0d_consec", v),
              obs[0][1].cyc - obs[0][0].cyc, 1);
    end

    // Overflow: 16 in FIFO, 1 pending, 5 dropped.
    do_reset();
    evt_ready = 1'b0;
    multi_hit = 1'b1;
    obs[0].delete();
    obs[1].delete();
    for (int o = 0; o < 54; o++) begin
      start_in = (o == 0);
      stop_in = {3'b000,
                 (o >= 2 && o <= 44 && o % 2 == 0)};
      tick();
    end
    check("ovf_full", full_o[0], 1);
    check("ovf_drop", drop_o[0], 5);
    check("ovf_drop_r0", drop_o[1], 5);
    check("ovf_valid", vld[0], 1);
    check("ovf_head_iv", iv_o[0], 2);
    tick();
    check("ovf_hold_iv", iv_o[0], 2);
    evt_ready = 1'b1;
    repeat (40) tick();
    for (int r = 0; r < 2; r++) begin
      check($sformatf("ovf_r%0d_count", r),
            obs[r].size(), 17);
      foreach (obs[r][i]) begin
        check($sformatf("ovf_r%0d_iv%0d", r, i),
              obs[r][i].iv, 2 + 2 * i);
        check($sformatf("ovf_r%0d_ch%0d", r, i),
              obs[r][i].chan, 0);
      end
    end
    check("ovf_full_after", full_o[0], 0);
    check("ovf_drop_after", drop_o[0], 5);

    // Reset mid-window with three pending channels.
    do_reset();
    evt_ready = 1'b0;
    multi_hit = 1'b1;
    for (int o = 0; o < 42; o++) begin
      start_in = (o == 0);
      stop_in = {(o == 36) ? 3'b111 : 3'b000,
                 (o >= 2 && o <= 32 && o % 2 == 0)};
      tick();
    end
    check("mid_busy_pre", busy_o[0], 1);
    check("mid_full_pre", full_o[0], 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_busy", busy_o[0], 0);
    check("mid_valid", vld[0], 0);
    check("mid_drop", drop_o[0], 0);
    check("mid_full", full_o[0], 0);
    evt_ready = 1'b1;
    obs[0].delete();
    obs[1].delete();
    repeat (100) tick();
    check("mid_no_evt_r1", obs[0].size(), 0);
    check("mid_no_evt_r0", obs[1].size(), 0);

    // Random stimulus against the window model.
    do_reset();
    evt_ready = 1'b1;
    obs[0].delete();
    obs[1].delete();
    for (int r = 0; r < 2; r++) begin
      ws[r]  = -1000000;
      hit[r] = '0;
    end
    for (int c = 0; c < 4; c++) gap[c] = 8;
    for (int ph = 0; ph < 2; ph++) begin
      multi_hit = (ph == 1);
      for (int k = 0; k < 1500; k++) begin
        ns = !start_in && ($urandom_range(0, 39) == 0);
        nstop = '0;
        for (int c = 0; c < 4; c++) begin
          if (!stop_in[c] && gap[c] >= 8 &&
              $urandom_range(0, 5) == 0) begin
            nstop[c] = 1'b1;
            gap[c] = 0;
          end else begin
            gap[c]++;
          end
        end
        model_step(ns & ~start_in, nstop & ~stop_in);
        start_in = ns;
        stop_in = nstop;
        tick();
      end
      start_in = 1'b0;
      stop_in = '0;
      for (int k = 0; k < 100; k++) begin
        model_step(1'b0, 4'b0000);
        tick();
      end
    end
    for (int r = 0; r < 2; r++) begin
      tot = 0;
      for (int c = 0; c < 4; c++) begin
        act.delete();
        foreach (obs[r][i])
          if (obs[r][i].chan == c)
            act.push_back(obs[r][i].iv);
        tot += expq[r*4+c].size();
        check($sformatf("rnd_r%0d_c%0d_count", r, c),
              act.size(), expq[r*4+c].size());
        foreach (act[i])
          if (i < expq[r*4+c].size())
            check($sformatf("rnd_r%0d_c%0d_iv%0d",
                            r, c, i),
                  act[i], expq[r*4+c][i]);
      end
      check($sformatf("rnd_r%0d_total", r),
            obs[r].size(), tot);
      check($sformatf("rnd_r%0d_drop", r),
            drop_o[r], 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
